// File: rtl/piece_move_ctrl_if.sv
// -----------------------------------------------------------------------------
// piece_move_ctrl_if
// Probe bus between the piece move controller and the shared collision checker.
//
// Signals
//   chk_x     candidate column presented to the checker
//   chk_y     candidate row presented to the checker
//   chk_valid 1-cycle strobe: chk_x/chk_y carry a new probe
//   collision checker answer, valid a fixed latency after chk_valid
//
// Handshake: chk_valid is a single-cycle strobe with no back-pressure. The
// checker must accept every strobe and return its answer on collision exactly
// CHECK_LAT cycles later. chk_x/chk_y hold their value between strobes.
//
// Modports
//   master  the controller (drives the probe, reads the answer)
//   slave   the checker (reads the probe, drives the answer)
// -----------------------------------------------------------------------------
interface piece_move_ctrl_if #(
    parameter int POS_W = 9
);
    logic [POS_W-1:0] chk_x;
    logic [POS_W-1:0] chk_y;
    logic             chk_valid;
    logic             collision;

    modport master (output chk_x, output chk_y, output chk_valid, input collision);
    modport slave  (input chk_x, input chk_y, input chk_valid, output collision);
endinterface

// File: rtl/piece_move_ctrl.sv
// -----------------------------------------------------------------------------
// piece_move_ctrl
// Sequences every move of the falling piece through one shared collision
// checker: latches left/right/down/gravity requests, arbitrates them, issues
// one candidate probe at a time, then commits, rejects or locks the piece.
// After a lock the piece respawns; a blocked spawn ends the game.
//
// Optional feature: define HARD_DROP_EN to add btn_drop and the DROP state,
// which probes downward back-to-back until collision or floor, then locks.
//
// Ports
//   clock, resetn   clock, asynchronous active-low reset
//   start           pulse: leave IDLE/OVER and spawn a piece
//   btn_left/right  pulse: request x-1 / x+1
//   btn_down        pulse: soft drop request y+1
//   grav_tick       pulse: gravity request y+1 (coalesces with btn_down)
//   btn_drop        pulse: hard drop (HARD_DROP_EN only)
//   chk             probe bus to the collision checker (master side)
//   piece_x/y       committed piece position
//   lock            1-cycle pulse: piece fixed at piece_x/piece_y
//   busy            high while spawning, probing or locking
//   game_over       high in OVER until start
//   dbg_state       current FSM state, for observation only
// -----------------------------------------------------------------------------
module piece_move_ctrl #(
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 20,
    parameter int POS_W     = 9,
    parameter int CHECK_LAT = 1,
    parameter int SPAWN_X   = 4,
    parameter int SPAWN_Y   = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             grav_tick,
`ifdef HARD_DROP_EN
    input  logic             btn_drop,
`endif
    piece_move_ctrl_if.master chk,
    output logic [POS_W-1:0] piece_x,
    output logic [POS_W-1:0] piece_y,
    output logic             lock,
    output logic             busy,
    output logic             game_over,
    output logic [2:0]       dbg_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;
`ifdef HARD_DROP_EN
    localparam logic [2:0] S_DROP  = 3'd6;
    localparam logic [2:0] OP_DROP = 3'd4;
`endif

    // What the outstanding probe was for, so WAIT knows how to apply it.
    localparam logic [2:0] OP_SPAWN = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;

    localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_W - 1);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(GRID_H - 1);
    localparam logic [POS_W-1:0] SPN_X = POS_W'(SPAWN_X);
    localparam logic [POS_W-1:0] SPN_Y = POS_W'(SPAWN_Y);
    localparam logic [POS_W-1:0] ONE   = POS_W'(1);
    localparam logic [2:0]       LAT_C = 3'(CHECK_LAT);

    logic [2:0]       state, state_nx;
    logic [2:0]       op, prb_op;
    logic [2:0]       cnt;
    logic             pend_l, pend_r, pend_d;
    logic             eff_l, eff_r, eff_d, in_play;
    logic             clr_l, clr_r, clr_d;
    logic             prb_go, commit_x, commit_y, load_spawn;
    logic [POS_W-1:0] prb_x, prb_y;
`ifdef HARD_DROP_EN
    logic             pend_h, eff_h, clr_h;
`endif

    // Requests are folded into the flags combinationally so a pulse seen by
    // READY is serviced in the same cycle (probe strobes the next cycle).
    assign in_play = (state != S_IDLE) && (state != S_OVER);
    assign eff_l   = pend_l | (in_play & btn_left);
    assign eff_r   = pend_r | (in_play & btn_right);
    assign eff_d   = pend_d | (in_play & (btn_down | grav_tick));
`ifdef HARD_DROP_EN
    assign eff_h   = pend_h | (in_play & btn_drop);
`endif

    always_comb begin
        state_nx   = state;
        prb_go     = 1'b0;
        prb_x      = piece_x;
        prb_y      = piece_y;
        prb_op     = OP_SPAWN;
        clr_l      = 1'b0;
        clr_r      = 1'b0;
        clr_d      = 1'b0;
        commit_x   = 1'b0;
        commit_y   = 1'b0;
        load_spawn = 1'b0;
`ifdef HARD_DROP_EN
        clr_h      = 1'b0;
`endif
        case (state)
            S_IDLE, S_OVER: begin
                if (start) state_nx = S_SPAWN;
            end
            S_SPAWN: begin
                prb_go = 1'b1;
                prb_x  = SPN_X;
                prb_y  = SPN_Y;
                prb_op = OP_SPAWN;
            end
            S_READY: begin
`ifdef HARD_DROP_EN
                if (eff_h) begin
                    {clr_h, clr_l, clr_r, clr_d} = 4'b1111;
                    state_nx = S_DROP;
                end else
`endif
                if (eff_l && eff_r) begin
                    // Opposing requests cancel each other.
                    clr_l = 1'b1;
                    clr_r = 1'b1;
                end else if (eff_l) begin
                    clr_l = 1'b1;
                    if (piece_x != '0) begin
                        prb_go = 1'b1;
                        prb_x  = piece_x - ONE;
                        prb_op = OP_LEFT;
                    end
                end else if (eff_r) begin
                    clr_r = 1'b1;
                    if (piece_x != X_MAX) begin
                        prb_go = 1'b1;
                        prb_x  = piece_x + ONE;
                        prb_op = OP_RIGHT;
                    end
                end else if (eff_d) begin
                    clr_d = 1'b1;
                    if (piece_y == Y_MAX) begin
                        state_nx = S_LOCK;      // on the floor: no probe needed
                    end else begin
                        prb_go = 1'b1;
                        prb_y  = piece_y + ONE;
                        prb_op = OP_DOWN;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == LAT_C) begin
                    case (op)
                        OP_SPAWN: begin
                            if (chk.collision) state_nx = S_OVER;
                            else begin
                                load_spawn = 1'b1;
                                state_nx   = S_READY;
                            end
                        end
                        OP_LEFT, OP_RIGHT: begin
                            commit_x = ~chk.collision;
                            state_nx = S_READY;
                        end
                        OP_DOWN: begin
                            commit_y = ~chk.collision;
                            state_nx = chk.collision ? S_LOCK : S_READY;
                        end
`ifdef HARD_DROP_EN
                        OP_DROP: begin
                            commit_y = ~chk.collision;
                            state_nx = chk.collision ? S_LOCK : S_DROP;
                        end
`endif
                        default: state_nx = S_READY;
                    endcase
                end
            end
            S_LOCK: begin
                clr_d    = 1'b1;
                state_nx = S_SPAWN;
            end
`ifdef HARD_DROP_EN
            S_DROP: begin
                if (piece_y == Y_MAX) begin
                    state_nx = S_LOCK;
                end else begin
                    prb_go = 1'b1;
                    prb_y  = piece_y + ONE;
                    prb_op = OP_DROP;
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
        if (prb_go) state_nx = S_WAIT;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            op            <= OP_SPAWN;
            cnt           <= '0;
            pend_l        <= 1'b0;
            pend_r        <= 1'b0;
            pend_d        <= 1'b0;
`ifdef HARD_DROP_EN
            pend_h        <= 1'b0;
`endif
            chk.chk_x     <= '0;
            chk.chk_y     <= '0;
            chk.chk_valid <= 1'b0;
            piece_x       <= SPN_X;
            piece_y       <= SPN_Y;
        end else begin
            state         <= state_nx;
            chk.chk_valid <= prb_go;
            if (prb_go) begin
                chk.chk_x <= prb_x;
                chk.chk_y <= prb_y;
                op        <= prb_op;
                cnt       <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 3'd1;
            end
            // Flags stay clear outside play, including the cycle we enter OVER.
            if (!in_play || state_nx == S_OVER) begin
                pend_l <= 1'b0;
                pend_r <= 1'b0;
                pend_d <= 1'b0;
`ifdef HARD_DROP_EN
                pend_h <= 1'b0;
`endif
            end else begin
                pend_l <= eff_l & ~clr_l;
                pend_r <= eff_r & ~clr_r;
                pend_d <= eff_d & ~clr_d;
`ifdef HARD_DROP_EN
                pend_h <= eff_h & ~clr_h;
`endif
            end
            // The probe registers still hold the candidate while WAIT resolves.
            if (load_spawn) begin
                piece_x <= SPN_X;
                piece_y <= SPN_Y;
            end
            if (commit_x) piece_x <= chk.chk_x;
            if (commit_y) piece_y <= chk.chk_y;
        end
    end

    assign busy      = (state == S_SPAWN) || (state == S_WAIT) || (state == S_LOCK)
`ifdef HARD_DROP_EN
                       || (state == S_DROP)
`endif
                       ;
    assign lock      = (state == S_LOCK);
    assign game_over = (state == S_OVER);
    assign dbg_state = state;
endmodule

// File: tb/tb_piece_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piece_move_ctrl
// Self-checking bench for piece_move_ctrl. A playfield array answers probes with
// the configured latency; a game-level model predicts every probe and lock,
// pushes them into exp_q, and a monitor pops and compares them as the DUT
// emits them. Piece position and game_over are compared after each request.
// -----------------------------------------------------------------------------
module tb_piece_move_ctrl;
    localparam int GRID_W = 10;
    localparam int GRID_H = 20;
    localparam int POS_W  = 9;
    localparam int LAT    = 3;
    localparam int SX     = 4;
    localparam int SY     = 0;
    localparam int EW     = 1 + 2 * POS_W;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic btn_down = 1'b0, grav_tick = 1'b0;
`ifdef HARD_DROP_EN
    logic btn_drop = 1'b0;
`endif
    logic [POS_W-1:0] piece_x, piece_y;
    logic             lock, busy, game_over;
    logic [2:0]       dbg_state;

    piece_move_ctrl_if #(.POS_W(POS_W)) chk_bus ();

    piece_move_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .POS_W(POS_W),
        .CHECK_LAT(LAT), .SPAWN_X(SX), .SPAWN_Y(SY)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_down(btn_down), .grav_tick(grav_tick),
`ifdef HARD_DROP_EN
        .btn_drop(btn_drop),
`endif
        .chk(chk_bus.master),
        .piece_x(piece_x), .piece_y(piece_y),
        .lock(lock), .busy(busy), .game_over(game_over),
        .dbg_state(dbg_state)
    );

    // ---------------- playfield / collision checker ----------------
    bit field [GRID_W][GRID_H];
    logic [LAT-1:0] vp, rp;

    function automatic bit cell_blocked(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
        if (int'(x) < GRID_W && int'(y) < GRID_H) return field[int'(x)][int'(y)];
        return 1'b1;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vp <= '0;
            rp <= '0;
        end else begin
            vp <= {vp[LAT-2:0], chk_bus.chk_valid};
            rp <= {rp[LAT-2:0], cell_blocked(chk_bus.chk_x, chk_bus.chk_y)};
        end
    end
    // Outside the answer cycle the line reads "blocked", so a mistimed sample shows up.
    assign chk_bus.collision = vp[LAT-1] ? rp[LAT-1] : 1'b1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [EW-1:0] ev(input bit is_lock, input int x, input int y);
        return {is_lock, POS_W'(x), POS_W'(y)};
    endfunction

    task automatic check_val(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_ev(input string name, input logic [EW-1:0] got);
        logic [EW-1:0] want;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got %h expected none", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                fails++;
                $display("FAIL %s: got %h expected %h", name, got, want);
            end
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (chk_bus.chk_valid) check_ev("probe", ev(1'b0, int'(chk_bus.chk_x), int'(chk_bus.chk_y)));
            if (lock) check_ev("lock", ev(1'b1, int'(piece_x), int'(piece_y)));
        end
    end

    // ---------------- reference model ----------------
    int mx = SX, my = SY;
    bit m_over = 1'b0;

    task automatic model_spawn();
        exp_q.push_back(ev(1'b0, SX, SY));
        if (field[SX][SY]) m_over = 1'b1;
        else begin
            mx = SX;
            my = SY;
        end
    endtask

    task automatic model_lock();
        exp_q.push_back(ev(1'b1, mx, my));
        field[mx][my] = 1'b1;
        model_spawn();
    endtask

    task automatic model_down();
        if (my == GRID_H - 1) model_lock();
        else begin
            exp_q.push_back(ev(1'b0, mx, my + 1));
            if (field[mx][my+1]) model_lock();
            else my++;
        end
    endtask

    // kinds: 0 left, 1 right, 2 btn_down, 3 grav_tick, 4 left+right, 5 hard drop
    task automatic model_req(input int kind);
        if (m_over) return;
        case (kind)
            0: if (mx > 0) begin
                   exp_q.push_back(ev(1'b0, mx - 1, my));
                   if (!field[mx-1][my]) mx--;
               end
            1: if (mx < GRID_W - 1) begin
                   exp_q.push_back(ev(1'b0, mx + 1, my));
                   if (!field[mx+1][my]) mx++;
               end
            2, 3: model_down();
            5: begin
                   while (my < GRID_H - 1 && !field[mx][my+1]) begin
                       exp_q.push_back(ev(1'b0, mx, my + 1));
                       my++;
                   end
                   if (my < GRID_H - 1) exp_q.push_back(ev(1'b0, mx, my + 1));
                   model_lock();
               end
            default: ;
        endcase
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic drive(input int kind);
        case (kind)
            0: btn_left = 1'b1;
            1: btn_right = 1'b1;
            2: btn_down = 1'b1;
            3: grav_tick = 1'b1;
            4: begin btn_left = 1'b1; btn_right = 1'b1; end
`ifdef HARD_DROP_EN
            5: btn_drop = 1'b1;
`endif
            default: ;
        endcase
        @(negedge clock);
        btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0; grav_tick = 1'b0;
`ifdef HARD_DROP_EN
        btn_drop = 1'b0;
`endif
    endtask

    task automatic settle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check_val("settle timeout", n, 0);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, " piece_x"}, int'(piece_x), mx);
        check_val({tag, " piece_y"}, int'(piece_y), my);
        check_val({tag, " game_over"}, int'(game_over), int'(m_over));
    endtask

    task automatic request(input int kind);
        model_req(kind);
        drive(kind);
        settle();
        check_state("req");
    endtask

    task automatic start_game();
        m_over = 1'b0;
        model_spawn();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        settle();
        check_state("start");
    endtask

    task automatic clear_field();
        foreach (field[x, y]) field[x][y] = 1'b0;
    endtask

    task automatic fill_field();
        foreach (field[x, y]) field[x][y] = ($urandom_range(0, 99) < 10);
        field[SX][SY] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int old_x;
        clear_field();
        repeat (3) @(negedge clock);
        check_val("reset piece_x", int'(piece_x), SX);
        check_val("reset piece_y", int'(piece_y), SY);
        check_val("reset chk_x", int'(chk_bus.chk_x), 0);
        check_val("reset chk_y", int'(chk_bus.chk_y), 0);
        check_val("reset outputs", int'({chk_bus.chk_valid, lock, busy, game_over}), 0);
        resetn = 1'b1;
        @(negedge clock);

        // Start, with three left pulses landing while the spawn is in flight.
        m_over = 1'b0;
        model_spawn();
        model_req(0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        btn_left = 1'b1;
        repeat (3) @(negedge clock);
        btn_left = 1'b0;
        settle();
        check_state("coalesce");
        check_val("coalesced x", int'(piece_x), 3);
        check_val("busy in ready", int'(busy), 0);

        // Request-to-commit latency.
        old_x = mx;
        model_req(1);
        btn_right = 1'b1;
        @(negedge clock);
        btn_right = 1'b0;
        repeat (LAT) @(negedge clock);
        check_val("latency before", int'(piece_x), old_x);
        @(negedge clock);
        check_val("latency commit", int'(piece_x), old_x + 1);
        settle();

        request(4);                       // left+right cancel: no probe
        field[SX][5] = 1'b1;
        repeat (5) request(3);            // stops at y=4, locks, respawns
        check_val("respawn x", int'(piece_x), SX);
        check_val("respawn y", int'(piece_y), SY);
        repeat (5) request(0);            // reaches x=0, last one rejected
        check_val("left edge", int'(piece_x), 0);
        repeat (20) request(2);           // reaches floor, last one locks unprobed
        check_val("floor cell locked", int'(field[0][GRID_H-1]), 1);

        // Blocked spawn.
        field[SX][SY] = 1'b1;
        request(1);
        repeat (20) request(2);
        check_val("game over", int'(game_over), 1);
        request(0);                       // ignored while over
        clear_field();
        start_game();
        check_val("game over cleared", int'(game_over), 0);

        // Reset during WAIT aborts the move.
        request(1);
        exp_q.push_back(ev(1'b0, mx, my + 1));
        grav_tick = 1'b1;
        @(negedge clock);
        grav_tick = 1'b0;
        #2 resetn = 1'b0;
        @(negedge clock);
        check_val("abort piece_x", int'(piece_x), SX);
        check_val("abort piece_y", int'(piece_y), SY);
        check_val("abort outputs", int'({chk_bus.chk_valid, lock, busy, game_over}), 0);
        exp_q.delete();
        mx = SX; my = SY; m_over = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        drive(0);                         // idle: no probe expected
        repeat (2) @(negedge clock);
        check_val("idle ignores", int'(busy), 0);
        start_game();

`ifdef HARD_DROP_EN
        request(5);
        check_val("drop floor lock", int'(field[SX][GRID_H-1]), 1);
`endif

        // Randomized play.
        fill_field();
        for (int i = 0; i < 300; i++) begin
            if (m_over) begin
                fill_field();
                start_game();
            end
`ifdef HARD_DROP_EN
            request($urandom_range(0, 9) == 0 ? 5 : $urandom_range(0, 4));
`else
            request($urandom_range(0, 4));
`endif
        end

        check_val("queue drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
